// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream that carries one captured register word together with its
// index and an end-of-dump marker.
interface regfile_dump_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks one register-file read port over FIRST_REG..LAST_REG and streams every word
// out over valid/ready, holding CPU writeback off so the snapshot stays consistent.
module regfile_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int FIRST_REG  = 0,
   parameter int LAST_REG   = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0] rf_data,
   regfile_dump_reader_if.master stream,
   output logic                  busy,
   output logic                  cpu_hold,
   output logic                  done
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(FIRST_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_REG);

   state_t                state_r;
   state_t                state_next_s;
   logic [ADDR_WIDTH-1:0] rf_addr_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic [ADDR_WIDTH-1:0] out_index_r;
   logic                  out_last_r;
   logic                  out_valid_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  handshake_s;
   logic                  capture_s;
   logic                  advance_s;
   logic                  clear_addr_s;
   logic                  drop_valid_s;

   assign handshake_s = out_valid_r & stream.out_ready;

   // Next-state decode and datapath strobes; abort outranks a simultaneous handshake.
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      advance_s    = 1'b0;
      clear_addr_s = 1'b0;
      drop_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = READ;
            end else begin
               state_next_s = IDLE;
            end
         end
         READ: begin
            if (abort) begin
               state_next_s = IDLE;
               clear_addr_s = 1'b1;
               drop_valid_s = 1'b1;
            end else begin
               state_next_s = SEND;
               capture_s    = 1'b1;
            end
         end
         SEND: begin
            if (abort) begin
               state_next_s = IDLE;
               clear_addr_s = 1'b1;
               drop_valid_s = 1'b1;
            end else if (handshake_s) begin
               drop_valid_s = 1'b1;
               if (out_last_r) begin
                  state_next_s = FIN;
               end else begin
                  state_next_s = READ;
                  advance_s    = 1'b1;
               end
            end else begin
               state_next_s = SEND;
            end
         end
         FIN: begin
            state_next_s = IDLE;
            clear_addr_s = 1'b1;
         end
         default: begin
            state_next_s = IDLE;
            clear_addr_s = 1'b1;
            drop_valid_s = 1'b1;
         end
      endcase
   end

   // State, address walker, capture register and registered status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         rf_addr_r   <= FIRST_ADDR;
         out_data_r  <= {DATA_WIDTH{1'b0}};
         out_index_r <= {ADDR_WIDTH{1'b0}};
         out_last_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_next_s;
         // Status flags follow the state being entered so they line up with it.
         busy_r  <= (state_next_s != IDLE);
         done_r  <= (state_next_s == FIN);
         if (clear_addr_s) begin
            rf_addr_r <= FIRST_ADDR;
         end else if (advance_s) begin
            rf_addr_r <= rf_addr_r + ADDR_WIDTH'(1);
         end else begin
            rf_addr_r <= rf_addr_r;
         end
         if (capture_s) begin
            out_data_r  <= rf_data;
            out_index_r <= rf_addr_r;
            out_last_r  <= (rf_addr_r == LAST_ADDR);
            out_valid_r <= 1'b1;
         end else if (drop_valid_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign rf_addr          = rf_addr_r;
   assign stream.out_valid = out_valid_r;
   assign stream.out_data  = out_data_r;
   assign stream.out_index = out_index_r;
   assign stream.out_last  = out_last_r;
   assign busy             = busy_r;
   assign cpu_hold         = busy_r;
   assign done             = done_r;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader: a register-file model feeds the read port and
// accepted words are compared against the index/value list the dump should produce.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        last;
      int          cyc;
   } word_t;
   typedef word_t wq_t[$];

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [AW-1:0] rf_addr, rf_addr1;
   logic [DW-1:0] rf_data, rf_data1;
   logic          busy, cpu_hold, done, busy1, cpu_hold1, done1;
   logic [DW-1:0] rf_mem [32];
   logic [DW-1:0] rf_mem1 [32];

   regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s0 ();
   regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1 ();

   regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(0), .LAST_REG(31)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rf_addr(rf_addr), .rf_data(rf_data), .stream(s0),
      .busy(busy), .cpu_hold(cpu_hold), .done(done));

   regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(5), .LAST_REG(5)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort1),
      .rf_addr(rf_addr1), .rf_data(rf_data1), .stream(s1),
      .busy(busy1), .cpu_hold(cpu_hold1), .done(done1));

   assign rf_data  = rf_mem[rf_addr];
   assign rf_data1 = rf_mem1[rf_addr1];

   always #5 clk = ~clk;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   word_t acc_q[$];
   int    done_q[$];
   int    hold_q[$];
   int    hb_mismatch = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Passive observer: words that will be accepted at the coming edge, done pulses, hold cycles.
   always @(negedge clk) begin
      if (!reset) begin
         if (s0.out_valid && s0.out_ready && !abort)
            acc_q.push_back('{int'(s0.out_index), s0.out_data, s0.out_last, cyc});
         if (done) done_q.push_back(cyc);
         if (cpu_hold) hold_q.push_back(cyc);
         if (cpu_hold !== busy) hb_mismatch++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic wq_t build_exp(input logic [DW-1:0] mem [32], input int first, input int last);
      wq_t   q;
      word_t w;
      for (int i = first; i <= last; i++) begin
         w.idx = i; w.data = mem[i]; w.last = (i == last); w.cyc = 0;
         q.push_back(w);
      end
      return q;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
   endtask

   // Pulse start, then run until the dump drains; optionally re-pulse start while busy.
   task automatic do_dump(input int ready_pct, input int restart_every, output int k, output bit timeout);
      s0.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      k = cyc;
      timeout = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (!busy) begin
            timeout = 1'b0;
            break;
         end
         s0.out_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < ready_pct);
         start = (restart_every > 0) && (n % restart_every == restart_every - 1) && (n < 58);
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s0.out_ready = 1'b0; s1.out_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin rf_mem[i] = 32'h0; rf_mem1[i] = 32'h0; end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (s0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s0.out_valid); end
      checks++; if (s0.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", s0.out_last); end
      checks++; if ({busy, cpu_hold, done} !== 3'b000) begin errors++; $display("FAIL reset_status: busy/hold/done=%b want 000", {busy, cpu_hold, done}); end
      checks++; if (s0.out_data !== 32'h0 || s0.out_index !== 5'd0) begin errors++; $display("FAIL reset_outputs: data=%h idx=%0d want 0/0", s0.out_data, s0.out_index); end
      checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
      checks++; if (rf_addr1 !== 5'd5) begin errors++; $display("FAIL reset_rf_addr_first5: got %0d want 5", rf_addr1); end
      reset = 1'b0;
      repeat (2) step();
      checks++; if (busy !== 1'b0 || s0.out_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0/0", busy, s0.out_valid); end
   endtask

   task automatic test_full_dump();
      int base, dbase, hbase, k;
      bit to;
      rf_mem[0] = 32'h0;
      for (int i = 1; i < 32; i++) rf_mem[i] = 32'h1000_0000 + i;
      base = acc_q.size(); dbase = done_q.size(); hbase = hold_q.size();
      do_dump(100, 0, k, to);
      checks++; if (to) begin errors++; $display("FAIL full_timeout: dump did not finish, got busy=%b want 0", busy); end
      checks++; if (acc_q.size() - base != 32) begin errors++; $display("FAIL full_count: got %0d words want 32", acc_q.size() - base); end
      for (int i = 0; i < 32 && base + i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[base+i].idx != i || acc_q[base+i].data !== ((i == 0) ? 32'h0 : 32'h1000_0000 + i) ||
             acc_q[base+i].last !== (i == 31) || acc_q[base+i].cyc != k + 1 + 2*i)
         begin
            errors++;
            $display("FAIL full_word[%0d]: got idx=%0d data=%h last=%b cyc=%0d want idx=%0d data=%h last=%b cyc=%0d",
                     i, acc_q[base+i].idx, acc_q[base+i].data, acc_q[base+i].last, acc_q[base+i].cyc,
                     i, (i == 0) ? 32'h0 : 32'h1000_0000 + i, (i == 31), k + 1 + 2*i);
         end
      end
      checks++;
      if (done_q.size() - dbase != 1 || (done_q.size() > dbase && done_q[dbase] != k + 64)) begin
         errors++;
         $display("FAIL full_done: got %0d pulses (first at %0d) want 1 at %0d", done_q.size() - dbase,
                  (done_q.size() > dbase) ? done_q[dbase] - k : -1, 64);
      end
      checks++;
      if (hold_q.size() - hbase != 65 || hold_q[hbase] != k || hold_q[hold_q.size()-1] != k + 64) begin
         errors++;
         $display("FAIL full_cpu_hold: got %0d cycles want 65 from edge %0d to %0d", hold_q.size() - hbase, k, k + 64);
      end
   endtask

   task automatic test_backpressure();
      wq_t         exp;
      int          base, dbase, stall;
      logic [31:0] hold_data;
      bit          to;
      fill_random();
      exp = build_exp(rf_mem, 0, 31);
      base = acc_q.size(); dbase = done_q.size();
      stall = 0; hold_data = 32'h0; to = 1'b1;
      s0.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!busy) begin to = 1'b0; break; end
         if (s0.out_valid && s0.out_index == 5'd3 && stall < 6) begin
            if (stall == 0) begin
               hold_data = s0.out_data;
               checks++; if (hold_data !== exp[3].data) begin errors++; $display("FAIL bp_first_data: got %h want %h", hold_data, exp[3].data); end
            end
            s0.out_ready = (stall >= 5);
            stall++;
         end else if (stall > 0 && stall < 6) begin
            checks++; errors++;
            $display("FAIL bp_stable[%0d]: valid=%b idx=%0d want 1/3", stall, s0.out_valid, s0.out_index);
            stall = 6;
            s0.out_ready = 1'b1;
         end else begin
            s0.out_ready = (int'($urandom_range(99, 0)) < 70);
         end
         if (stall > 1 && stall <= 6 && s0.out_valid && s0.out_index == 5'd3) begin
            checks++;
            if (s0.out_data !== hold_data) begin errors++; $display("FAIL bp_stable_data[%0d]: got %h want %h", stall, s0.out_data, hold_data); end
         end
         step();
      end
      checks++; if (to || stall != 6) begin errors++; $display("FAIL bp_progress: timeout=%b stall_cycles=%0d want 0/6", to, stall); end
      checks++; if (acc_q.size() - base != 32) begin errors++; $display("FAIL bp_count: got %0d words want 32", acc_q.size() - base); end
      for (int i = 0; i < 32 && base + i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[base+i].idx != exp[i].idx || acc_q[base+i].data !== exp[i].data || acc_q[base+i].last !== exp[i].last) begin
            errors++;
            $display("FAIL bp_word[%0d]: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b", i,
                     acc_q[base+i].idx, acc_q[base+i].data, acc_q[base+i].last, exp[i].idx, exp[i].data, exp[i].last);
         end
      end
      checks++; if (done_q.size() - dbase != 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_q.size() - dbase); end
   endtask

   task automatic test_abort();
      wq_t exp;
      int  base, dbase, k;
      bit  found, to;
      fill_random();
      exp = build_exp(rf_mem, 0, 31);
      base = acc_q.size(); dbase = done_q.size();
      s0.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (s0.out_valid && s0.out_index == 5'd10) begin found = 1'b1; break; end
         step();
      end
      checks++; if (!found) begin errors++; $display("FAIL abort_reach10: got no index 10 want index 10 in SEND"); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++; if (s0.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", s0.out_valid); end
      checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL abort_busy: busy=%b hold=%b want 0/0", busy, cpu_hold); end
      checks++; if (rf_addr !== 5'd0) begin errors++; $display("FAIL abort_rf_addr: got %0d want 0", rf_addr); end
      repeat (5) step();
      checks++;
      if (acc_q.size() - base != 10 || acc_q[acc_q.size()-1].idx != 9 || acc_q[acc_q.size()-1].data !== exp[9].data) begin
         errors++;
         $display("FAIL abort_consumed: got %0d words (last idx %0d) want 10 (last idx 9)", acc_q.size() - base, acc_q[acc_q.size()-1].idx);
      end
      checks++; if (done_q.size() != dbase) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_q.size() - dbase); end
      base = acc_q.size(); dbase = done_q.size();
      do_dump(60, 0, k, to);
      checks++; if (to || acc_q.size() - base != 32) begin errors++; $display("FAIL abort_restart_count: got %0d words timeout=%b want 32/0", acc_q.size() - base, to); end
      for (int i = 0; i < 32 && base + i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[base+i].idx != exp[i].idx || acc_q[base+i].data !== exp[i].data || acc_q[base+i].last !== exp[i].last) begin
            errors++;
            $display("FAIL abort_restart_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i,
                     acc_q[base+i].idx, acc_q[base+i].data, exp[i].idx, exp[i].data);
         end
      end
      checks++; if (done_q.size() - dbase != 1) begin errors++; $display("FAIL abort_restart_done: got %0d pulses want 1", done_q.size() - dbase); end
   endtask

   task automatic test_reset_mid();
      wq_t exp;
      int  base, dbase, k;
      bit  found, to;
      fill_random();
      exp = build_exp(rf_mem, 0, 31);
      dbase = done_q.size();
      s0.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (s0.out_valid && s0.out_index == 5'd17) begin found = 1'b1; break; end
         step();
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_reach17: got no index 17 want index 17"); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if ({s0.out_valid, s0.out_last, busy, cpu_hold, done} !== 5'b0) begin errors++; $display("FAIL rst_flags: valid/last/busy/hold/done=%b want 00000", {s0.out_valid, s0.out_last, busy, cpu_hold, done}); end
      checks++; if (s0.out_data !== 32'h0 || s0.out_index !== 5'd0 || rf_addr !== 5'd0) begin errors++; $display("FAIL rst_values: data=%h idx=%0d addr=%0d want 0/0/0", s0.out_data, s0.out_index, rf_addr); end
      repeat (2) step();
      reset = 1'b0;
      repeat (3) step();
      checks++; if (done_q.size() != dbase) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_q.size() - dbase); end
      base = acc_q.size();
      do_dump(100, 0, k, to);
      checks++; if (to || acc_q.size() - base != 32) begin errors++; $display("FAIL rst_restart_count: got %0d words timeout=%b want 32/0", acc_q.size() - base, to); end
      for (int i = 0; i < 32 && base + i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[base+i].idx != exp[i].idx || acc_q[base+i].data !== exp[i].data || acc_q[base+i].last !== exp[i].last) begin
            errors++;
            $display("FAIL rst_restart_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i,
                     acc_q[base+i].idx, acc_q[base+i].data, exp[i].idx, exp[i].data);
         end
      end
   endtask

   task automatic test_single_reg();
      int          words, dones, idx;
      logic [31:0] data;
      logic        last;
      for (int i = 0; i < 32; i++) rf_mem1[i] = $urandom;
      rf_mem1[5] = 32'hDEAD_BEEF;
      words = 0; dones = 0; idx = -1; data = 32'h0; last = 1'b0;
      s1.out_ready = 1'b1;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      checks++; if (rf_addr1 !== 5'd5 || busy1 !== 1'b1) begin errors++; $display("FAIL single_read: addr=%0d busy=%b want 5/1", rf_addr1, busy1); end
      for (int n = 0; n < 20; n++) begin
         if (s1.out_valid && s1.out_ready) begin
            words++; idx = int'(s1.out_index); data = s1.out_data; last = s1.out_last;
         end
         if (done1) dones++;
         step();
      end
      checks++; if (words != 1) begin errors++; $display("FAIL single_count: got %0d words want 1", words); end
      checks++; if (idx != 5 || last !== 1'b1 || data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_word: got idx=%0d last=%b data=%h want 5/1/deadbeef", idx, last, data); end
      checks++; if (dones != 1 || busy1 !== 1'b0) begin errors++; $display("FAIL single_done: got %0d pulses busy=%b want 1/0", dones, busy1); end
   endtask

   task automatic test_back_to_back_start();
      wq_t exp;
      int  base, dbase, hbase, k;
      bit  to;
      fill_random();
      exp = build_exp(rf_mem, 0, 31);
      base = acc_q.size(); dbase = done_q.size(); hbase = hold_q.size();
      do_dump(100, 3, k, to);
      repeat (4) step();
      checks++; if (to || acc_q.size() - base != 32) begin errors++; $display("FAIL restart_count: got %0d words timeout=%b want 32/0", acc_q.size() - base, to); end
      for (int i = 0; i < 32 && base + i < acc_q.size(); i++) begin
         checks++;
         if (acc_q[base+i].idx != exp[i].idx || acc_q[base+i].data !== exp[i].data || acc_q[base+i].last !== exp[i].last) begin
            errors++;
            $display("FAIL restart_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i,
                     acc_q[base+i].idx, acc_q[base+i].data, exp[i].idx, exp[i].data);
         end
      end
      checks++; if (done_q.size() - dbase != 1) begin errors++; $display("FAIL restart_done: got %0d pulses want 1", done_q.size() - dbase); end
      checks++;
      if (hold_q.size() - hbase != 65 || hold_q[hbase] != k || hold_q[hold_q.size()-1] != k + 64) begin
         errors++;
         $display("FAIL restart_cpu_hold: got %0d cycles want 65 from edge %0d to %0d", hold_q.size() - hbase, k, k + 64);
      end
      checks++; if (hb_mismatch != 0) begin errors++; $display("FAIL cpu_hold_eq_busy: got %0d differing cycles want 0", hb_mismatch); end
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_single_reg();
      test_back_to_back_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
